// File: rtl/button_conditioner.sv
// Button conditioner: per-channel 2-flop synchronizer feeding an independent
// debounce / hold / auto-repeat FSM that emits one-cycle pulses and a debounced level.
module button_conditioner #(
  parameter int              NBTN            = 5,
  parameter int              DEBOUNCE_CYCLES = 1000000,
  parameter int              REPEAT_DELAY    = 50000000,
  parameter int              REPEAT_RATE     = 15000000,
  parameter logic [NBTN-1:0] REPEAT_MASK     = 5'b01111
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] i_buttons,
  output logic [NBTN-1:0] o_pulse,
  output logic [NBTN-1:0] o_level
);

  // Floors of 2 on the repeat timings keep pulses off back-to-back cycles.
  localparam int DEB     = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int DLY     = (REPEAT_DELAY < 2) ? 2 : REPEAT_DELAY;
  localparam int RATE    = (REPEAT_RATE < 2) ? 2 : REPEAT_RATE;
  localparam int MAX_DR  = (DLY > RATE) ? DLY : RATE;
  localparam int CNT_MAX = (DEB > MAX_DR) ? DEB : MAX_DR;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_SAT   = cnt_t'(CNT_MAX);
  localparam cnt_t DEB_LAST  = cnt_t'(DEB - 1);
  localparam cnt_t DLY_LAST  = cnt_t'(DLY - 1);
  localparam cnt_t RATE_LAST = cnt_t'(RATE - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REPEAT,
    RELEASE_DB
  } state_t;

  logic [NBTN-1:0] sync_p0;
  logic [NBTN-1:0] sync_p1;
  state_t          state_q [NBTN];
  state_t          state_d [NBTN];
  cnt_t            cnt_q   [NBTN];
  cnt_t            cnt_d   [NBTN];
  logic [NBTN-1:0] pulse_d;
  logic [NBTN-1:0] level_d;

  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == CNT_SAT) ? c : c + cnt_t'(1);
  endfunction

  // Next-state: counters hold the number of consecutive qualifying cycles seen.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = '0;
    level_d = o_level;
    for (int i = 0; i < NBTN; i++) begin
      case (state_q[i])
        IDLE: begin
          cnt_d[i] = '0;
          if (sync_p1[i]) begin
            if (DEB == 1) begin
              state_d[i] = HELD;
              pulse_d[i] = 1'b1;
              level_d[i] = 1'b1;
            end else begin
              state_d[i] = PRESS_DB;
              cnt_d[i]   = cnt_t'(1);
            end
          end
        end
        PRESS_DB: begin
          if (!sync_p1[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= DEB_LAST) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
            pulse_d[i] = 1'b1;
            level_d[i] = 1'b1;
          end else begin
            cnt_d[i] = sat_inc(cnt_q[i]);
          end
        end
        HELD, REPEAT: begin
          if (!sync_p1[i]) begin
            if (DEB == 1) begin
              state_d[i] = IDLE;
              cnt_d[i]   = '0;
              level_d[i] = 1'b0;
            end else begin
              state_d[i] = RELEASE_DB;
              cnt_d[i]   = cnt_t'(1);
            end
          end else if (state_q[i] == HELD) begin
            if (REPEAT_MASK[i] && (cnt_q[i] >= DLY_LAST)) begin
              state_d[i] = REPEAT;
              cnt_d[i]   = '0;
              pulse_d[i] = 1'b1;
            end else begin
              cnt_d[i] = sat_inc(cnt_q[i]);
            end
          end else if (cnt_q[i] >= RATE_LAST) begin
            cnt_d[i]   = '0;
            pulse_d[i] = 1'b1;
          end else begin
            cnt_d[i] = sat_inc(cnt_q[i]);
          end
        end
        RELEASE_DB: begin
          // A bounce back high resumes the hold but restarts the repeat delay.
          if (sync_p1[i]) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= DEB_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            level_d[i] = 1'b0;
          end else begin
            cnt_d[i] = sat_inc(cnt_q[i]);
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Stage p0/p1: synchronizer; FSM state and registered outputs follow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      o_pulse <= '0;
      o_level <= '0;
      for (int i = 0; i < NBTN; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync_p0 <= i_buttons;
      sync_p1 <= sync_p0;
      o_pulse <= pulse_d;
      o_level <= level_d;
      for (int i = 0; i < NBTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

endmodule
